// File: rtl/ivector_req_arbiter.sv
// ivector_req_arbiter
// Shares one say/heard server channel between NUM_CLIENTS requesters.
// Each client owns a one-entry buffer. Buffers are granted round-robin onto the
// server say channel. The index of each issued client is pushed into an
// in-order tag FIFO. Because the echo path preserves order, the tag FIFO head
// tells us which client each returning heard payload belongs to.
module ivector_req_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int WIDTH       = 96,
    parameter int TAG_DEPTH   = 4
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic [NUM_CLIENTS-1:0]           cl_say__ENA,
    input  logic [NUM_CLIENTS*WIDTH-1:0]     cl_say_v,
    output logic [NUM_CLIENTS-1:0]           cl_say__RDY,
    output logic                             srv_say__ENA,
    output logic [WIDTH-1:0]                 srv_say_v,
    input  logic                             srv_say__RDY,
    input  logic                             srv_heard__ENA,
    input  logic [WIDTH-1:0]                 srv_heard_v,
    output logic                             srv_heard__RDY,
    output logic [NUM_CLIENTS-1:0]           cl_heard__ENA,
    output logic [WIDTH-1:0]                 cl_heard_v,
    input  logic [NUM_CLIENTS-1:0]           cl_heard__RDY,
    output logic [$clog2(TAG_DEPTH+1)-1:0]   inflight,
    output logic                             err_unexp
);

    localparam int IDXW = $clog2(NUM_CLIENTS);
    localparam int TAGW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNTW = $clog2(TAG_DEPTH + 1);

    logic [NUM_CLIENTS-1:0] bvalid;
    logic [WIDTH-1:0]       bdata [NUM_CLIENTS];
    logic [IDXW-1:0]        ptr;

    logic [IDXW-1:0]        tags [TAG_DEPTH];
    logic [TAGW-1:0]        wr_ptr;
    logic [TAGW-1:0]        rd_ptr;
    logic [CNTW-1:0]        count;
    logic                   err_q;

    logic                   found;
    logic [IDXW-1:0]        winner;
    logic                   issue;
    logic                   pop;
    logic [IDXW-1:0]        head;
    logic [NUM_CLIENTS-1:0] accept;

    // Round-robin search: first valid buffer at or after ptr, wrapping.
    always_comb begin
        int              idx;
        logic [IDXW-1:0] cand;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CLIENTS) begin
                idx = idx - NUM_CLIENTS;
            end
            cand = IDXW'(idx);
            if (!found && bvalid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Full tag FIFO blocks issue even when a pop happens this same cycle,
    // so issue only looks at the registered count.
    assign issue        = nRST && found && srv_say__RDY && (count < CNTW'(TAG_DEPTH));
    assign srv_say__ENA = issue;
    assign srv_say_v    = bdata[winner];

    // Guards are forced low during reset so nothing handshakes while nRST is low.
    assign cl_say__RDY  = nRST ? ~bvalid : '0;
    assign accept       = cl_say__ENA & cl_say__RDY;

    assign head           = tags[rd_ptr];
    assign srv_heard__RDY = nRST && (count != '0) && cl_heard__RDY[head];
    assign pop            = srv_heard__ENA && srv_heard__RDY;
    assign cl_heard_v     = srv_heard_v;
    assign inflight       = count;
    assign err_unexp      = err_q;

    // Route the heard enable to the client at the tag FIFO head.
    always_comb begin
        cl_heard__ENA = '0;
        if (pop) begin
            cl_heard__ENA[head] = 1'b1;
        end
    end

    // Buffer valid flags and round-robin pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bvalid <= '0;
            ptr    <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (accept[i]) begin
                    bvalid[i] <= 1'b1;
                end else if (issue && (winner == IDXW'(i))) begin
                    bvalid[i] <= 1'b0;
                end
            end
            if (issue) begin
                ptr <= (winner == IDXW'(NUM_CLIENTS - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    // Buffer payload storage; contents are meaningless while the valid flag is low.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (accept[i]) begin
                bdata[i] <= cl_say_v[i*WIDTH +: WIDTH];
            end
        end
    end

    // Tag FIFO storage, written with the winning client index on issue.
    always_ff @(posedge CLK) begin
        if (issue) begin
            tags[wr_ptr] <= winner;
        end
    end

    // Tag FIFO pointers, occupancy and sticky unexpected-heard flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (issue) begin
                wr_ptr <= (wr_ptr == TAGW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == TAGW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({issue, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (srv_heard__ENA && (count == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ivector_req_arbiter.md
Name: ivector_req_arbiter

Overview:
- Shares one IVector request/indication pair (say -> FifoPong-backed echo -> heard) between NUM_CLIENTS requesters.
- Each client has a one-entry input buffer; buffers are granted round-robin onto the single server say channel.
- Each issue pushes the winning client index into an in-order tag FIFO.
- The tag FIFO routes each returning heard payload back to the originating client. The echo path preserves order, so no tags are carried in the payload.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- WIDTH, 96, ValuePair payload width (a, b, c, 32 bits each).
- TAG_DEPTH, 4, maximum in-flight say transactions awaiting heard; power of 2.

Ports:
- CLK  in  1  clock; all state on rising edge
- nRST  in  1  asynchronous, active-low reset
- cl_say__ENA  in  NUM_CLIENTS  per-client say enable
- cl_say_v  in  NUM_CLIENTS*WIDTH  per-client payload; client i at [i*WIDTH +: WIDTH]
- cl_say__RDY  out  NUM_CLIENTS  per-client say guard
- srv_say__ENA  out  1  say enable to shared server
- srv_say_v  out  WIDTH  payload to server
- srv_say__RDY  in  1  server say guard
- srv_heard__ENA  in  1  heard enable from server side
- srv_heard_v  in  WIDTH  heard payload
- srv_heard__RDY  out  1  heard guard presented to server side
- cl_heard__ENA  out  NUM_CLIENTS  per-client heard enable (one-hot or zero)
- cl_heard_v  out  WIDTH  heard payload, broadcast to all clients
- cl_heard__RDY  in  NUM_CLIENTS  per-client heard guard
- inflight  out  $clog2(TAG_DEPTH+1)  tag FIFO occupancy
- err_unexp  out  1  sticky: heard arrived with no tag outstanding

Behaviour:
- Handshake: a transfer occurs on a cycle where ENA && RDY. RDY never depends combinationally on the same channel's ENA. ENA while RDY low is illegal and ignored (no state change).
- Reset (nRST low, async): all buffers invalid, ptr=0, tag FIFO empty, inflight=0, err_unexp=0. All ENA and RDY outputs are 0 while nRST is low. srv_say_v and cl_heard_v are don't-care.
- Input stage: cl_say__RDY[i] = !bvalid[i]. On cl_say__ENA[i] && RDY: bdata[i] <= payload, bvalid[i] <= 1.
  - Min latency client accept -> srv_say__ENA is 1 cycle.
  - A buffer cannot be refilled in the same cycle it drains (no bypass). Max throughput per client is 1 per 2 cycles; aggregate throughput is 1 per cycle.
- Arbitration: winner = first i with bvalid[i], searching cyclically from ptr.
  - issue = any bvalid && srv_say__RDY && (inflight < TAG_DEPTH).
  - srv_say__ENA = issue; srv_say_v = bdata[winner].
  - On issue: bvalid[winner] <= 0; ptr <= (winner+1) mod NUM_CLIENTS; push winner into tag FIFO.
  - No issue: ptr holds.
- Tag full: inflight == TAG_DEPTH blocks issue, even if a heard pops in the same cycle (no push/pop bypass at full). Push and pop in the same cycle below full is allowed; inflight unchanged.
- Return path: head = tag FIFO head.
  - srv_heard__RDY = (inflight != 0) && cl_heard__RDY[head].
  - cl_heard__ENA[i] = srv_heard__ENA && srv_heard__RDY && (head == i).
  - cl_heard_v = srv_heard_v.
  - On transfer: pop the tag FIFO.
  - Return latency is 0 cycles (combinational pass-through).
- err_unexp: set on srv_heard__ENA while inflight == 0 (illegal but detected). Cleared only by reset. No pop, no client ENA.
- Pointers: tag FIFO rd/wr pointers wrap mod TAG_DEPTH. inflight is an exact count 0..TAG_DEPTH.
- Reset mid-operation discards all buffered requests and outstanding tags. Heard responses still in the echo path after reset are the system's concern; they raise err_unexp.

Test Plan:
- Single client: client 0 sends a=1, b=2, c=3 at cycle 5 → srv_say__ENA at cycle 6 with same payload, inflight=1. Server returns heard 1/2/3 → cl_heard__ENA=0001 that cycle, inflight=0.
- Round-robin: all 4 clients enqueue payload a=i in the same cycle, ptr=0, srv_say__RDY=1 → issues in order 0,1,2,3 on consecutive cycles. Client 1 re-enqueues after its issue → next order is 1 once ptr wraps past 3.
- Tag full: TAG_DEPTH=4, 4 issues with no heard → inflight=4, srv_say__ENA stays 0 with a pending buffer. One heard in a cycle → issue resumes only the following cycle.
- Return stall: tags [2,0]; cl_heard__RDY[2]=0 → srv_heard__RDY=0. Raise RDY[2] → heard to client 2, then heard to client 0, in order.
- Server stall: srv_say__RDY=0 for 10 cycles with all buffers full → cl_say__RDY=0000, ptr unchanged, no issue.
- Reset and error: drop nRST mid-burst (inflight=3) → all outputs 0 immediately, inflight=0 after release. Next srv_heard__ENA → err_unexp=1 and stays 1.
